// File: rtl/nco_phase_gen.sv
// nco_phase_gen
//   Numerically controlled oscillator producing the 20-bit signed phase word
//   for the CORDIC sin/cos rotator on the colour-subcarrier path. A phase
//   accumulator advances by the active tuning word every cycle. It is
//   realigned to start_phase at each line start, and tuning-word updates only
//   take effect on line boundaries. Valid and line-start sideband flags are
//   delayed by the rotator latency so they stay aligned with sin/cos.
//
//   Optional build macro: NCO_PAL_ALT_EN
//     When defined, line_parity toggles on every line start. Lines with
//     parity 1 start 180 deg away from start_phase.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     enable              run request; low forces IDLE
//     ftw_in, ftw_load    tuning word and its capture strobe (into shadow)
//     line_sync           line-start strobe (ignored in IDLE)
//     start_phase         phase loaded at line start (2^20 = 360 deg)
//     phase_out           signed phase to the rotator
//     phase_valid         phase_out is meaningful
//     ftw_pending         shadow tuning word not yet applied
//     cordic_valid        phase_valid delayed CORDIC_LATENCY cycles
//     cordic_line_start   line-start marker delayed CORDIC_LATENCY cycles
//     line_parity         per-line toggle (0 unless NCO_PAL_ALT_EN)
//
//   state | meaning
//   IDLE  | accumulator held at 0, phase invalid
//   RUN   | accumulating; line starts realign phase and apply shadow FTW

module nco_phase_gen #(
    parameter int ACC_WIDTH      = 32,
    parameter int CORDIC_LATENCY = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [ACC_WIDTH-1:0] ftw_in,
    input  logic                 ftw_load,
    input  logic                 line_sync,
    input  logic [19:0]          start_phase,
    output logic [19:0]          phase_out,
    output logic                 phase_valid,
    output logic                 ftw_pending,
    output logic                 cordic_valid,
    output logic                 cordic_line_start,
    output logic                 line_parity
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int SHIFT = ACC_WIDTH - 20;

    state_t                    state;
    logic [ACC_WIDTH-1:0]      acc;
    logic [ACC_WIDTH-1:0]      ftw_active;
    logic [ACC_WIDTH-1:0]      ftw_shadow;
    logic                      line_start;
    logic [CORDIC_LATENCY-1:0] vld_dly;
    logic [CORDIC_LATENCY-1:0] ls_dly;
    logic [19:0]               start_eff;
    logic                      line_start_evt;

    // Leaving IDLE counts as a line start so the first line is aligned.
    assign line_start_evt = enable && ((state == IDLE) || line_sync);

`ifdef NCO_PAL_ALT_EN
    logic parity_q;

    // The offset follows the post-toggle parity, i.e. the inverse of parity_q.
    assign start_eff   = parity_q ? start_phase : start_phase + 20'h80000;
    assign line_parity = parity_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            parity_q <= 1'b0;
        else if (line_start_evt)
            parity_q <= ~parity_q;
    end
`else
    assign start_eff   = start_phase;
    assign line_parity = 1'b0;
`endif

    assign phase_out         = acc[ACC_WIDTH-1 -: 20];
    assign cordic_valid      = vld_dly[CORDIC_LATENCY-1];
    assign cordic_line_start = ls_dly[CORDIC_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            ftw_active  <= '0;
            ftw_shadow  <= '0;
            ftw_pending <= 1'b0;
            phase_valid <= 1'b0;
            line_start  <= 1'b0;
            vld_dly     <= '0;
            ls_dly      <= '0;
        end else begin
            // Delay lines keep shifting in every state so entries drain.
            vld_dly <= {vld_dly[CORDIC_LATENCY-2:0], phase_valid};
            ls_dly  <= {ls_dly[CORDIC_LATENCY-2:0], line_start};

            if (!enable) begin
                state       <= IDLE;
                acc         <= '0;
                phase_valid <= 1'b0;
                line_start  <= 1'b0;
            end else if (line_start_evt) begin
                state       <= RUN;
                acc         <= ACC_WIDTH'(start_eff) << SHIFT;
                phase_valid <= 1'b1;
                line_start  <= 1'b1;
                if (ftw_pending) begin
                    ftw_active  <= ftw_shadow;
                    ftw_pending <= 1'b0;
                end
            end else begin
                acc         <= acc + ftw_active;
                phase_valid <= 1'b1;
                line_start  <= 1'b0;
            end

            // Placed last so a load coinciding with a line start stays
            // pending; the apply above still sees the previous shadow.
            if (ftw_load) begin
                ftw_shadow  <= ftw_in;
                ftw_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_gen.sv
module tb_nco_phase_gen;

    localparam int L = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [31:0] ftw_in;
    logic        ftw_load;
    logic        line_sync;
    logic [19:0] start_phase;
    logic [19:0] phase_out;
    logic        phase_valid;
    logic        ftw_pending;
    logic        cordic_valid;
    logic        cordic_line_start;
    logic        line_parity;

    int checks = 0;
    int errors = 0;

    // Reference model state: a running flag, the phase accumulator as plain
    // modulo-2^32 arithmetic, tuning words, and a history of per-cycle flags.
    bit          m_run;
    logic [31:0] m_acc;
    logic [31:0] m_ftw;
    logic [31:0] m_sh;
    bit          m_pend;
    bit          m_pv;
    bit          m_lsr;
    bit          m_par;
    bit          pv_hist[$];
    bit          ls_hist[$];

    logic [19:0] p0;

    always #5 clk = ~clk;

    nco_phase_gen #(.ACC_WIDTH(32), .CORDIC_LATENCY(L)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .ftw_in           (ftw_in),
        .ftw_load         (ftw_load),
        .line_sync        (line_sync),
        .start_phase      (start_phase),
        .phase_out        (phase_out),
        .phase_valid      (phase_valid),
        .ftw_pending      (ftw_pending),
        .cordic_valid     (cordic_valid),
        .cordic_line_start(cordic_line_start),
        .line_parity      (line_parity)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pal_off();
`ifdef NCO_PAL_ALT_EN
        return m_par ? 20'h80000 : 20'h00000;
`else
        return 20'h00000;
`endif
    endfunction

    task automatic model_reset();
        m_run = 0; m_acc = '0; m_ftw = '0; m_sh = '0;
        m_pend = 0; m_pv = 0; m_lsr = 0; m_par = 0;
        pv_hist.delete();
        ls_hist.delete();
    endtask

    task automatic model_clock(input bit en, input bit ld, input logic [31:0] fin,
                               input bit ls, input logic [19:0] sp);
        bit new_line;
        logic [19:0] ph;
        new_line = 0;
        if (!en) begin
            m_run = 0; m_acc = '0; m_pv = 0; m_lsr = 0;
        end else if (!m_run || ls) begin
            new_line = 1;
        end else begin
            m_acc = m_acc + m_ftw;
            m_pv  = 1;
            m_lsr = 0;
        end
        if (new_line) begin
`ifdef NCO_PAL_ALT_EN
            m_par = !m_par;
`endif
            ph    = sp ^ pal_off();
            m_acc = {ph, 12'h000};
            m_run = 1; m_pv = 1; m_lsr = 1;
            if (m_pend) begin
                m_ftw  = m_sh;
                m_pend = 0;
            end
        end
        if (ld) begin
            m_sh   = fin;
            m_pend = 1;
        end
        pv_hist.push_back(m_pv);
        ls_hist.push_back(m_lsr);
    endtask

    task automatic check_all();
        int k;
        bit ecv, ecls;
        k    = pv_hist.size();
        ecv  = (k > L) ? pv_hist[k-1-L] : 1'b0;
        ecls = (k > L) ? ls_hist[k-1-L] : 1'b0;
        chk("phase_out",   32'(phase_out),         32'(m_acc[31:12]));
        chk("phase_valid", 32'(phase_valid),       32'(m_pv));
        chk("ftw_pending", 32'(ftw_pending),       32'(m_pend));
        chk("cordic_valid", 32'(cordic_valid),     32'(ecv));
        chk("cordic_ls",   32'(cordic_line_start), 32'(ecls));
        chk("line_parity", 32'(line_parity),       32'(m_par));
    endtask

    task automatic step(input bit en, input bit ld, input logic [31:0] fin,
                        input bit ls, input logic [19:0] sp);
        enable = en; ftw_load = ld; ftw_in = fin; line_sync = ls; start_phase = sp;
        @(posedge clk);
        model_clock(en, ld, fin, ls, sp);
        #1;
        check_all();
        ftw_load  = 1'b0;
        line_sync = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_phase"}, 32'(phase_out), 32'h0);
        chk({tag, "_pv"},    32'(phase_valid), 32'h0);
        chk({tag, "_pend"},  32'(ftw_pending), 32'h0);
        chk({tag, "_cv"},    32'(cordic_valid), 32'h0);
        chk({tag, "_cls"},   32'(cordic_line_start), 32'h0);
        chk({tag, "_par"},   32'(line_parity), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; ftw_in = '0; ftw_load = 1'b0;
        line_sync = 1'b0; start_phase = '0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic accumulation: load in IDLE, then enable at phase 0.
        step(0, 1, 32'h0100_0000, 0, 20'h0);
        chk("pend_idle", 32'(ftw_pending), 32'h1);
        step(1, 0, 32'h0, 0, 20'h0);
        chk("first_phase", 32'(phase_out), 32'(pal_off()));
        chk("first_valid", 32'(phase_valid), 32'h1);
        step(1, 0, 32'h0, 0, 20'h0);
        chk("second_phase", 32'(phase_out), 32'(20'h01000 ^ pal_off()));
        for (int i = 0; i < 255; i++) step(1, 0, 32'h0, 0, 20'h0);
        chk("wrap_256", 32'(phase_out), 32'(pal_off()));
        for (int i = 0; i < 5; i++) step(1, 0, 32'h0, 0, 20'h0);

        // Line realignment.
        step(1, 0, 32'h0, 1, 20'h40000);
        chk("realign", 32'(phase_out), 32'(20'h40000 ^ pal_off()));
        step(1, 0, 32'h0, 0, 20'h40000);
        chk("realign_next", 32'(phase_out), 32'(20'h41000 ^ pal_off()));
        for (int i = 0; i < 9; i++) step(1, 0, 32'h0, 0, 20'h40000);
        chk("cls_delay", 32'(cordic_line_start), 32'h1);
        step(1, 0, 32'h0, 0, 20'h40000);
        chk("cls_one_cycle", 32'(cordic_line_start), 32'h0);

        // Deferred FTW.
        step(1, 1, 32'h0200_0000, 0, 20'h0);
        chk("defer_pend", 32'(ftw_pending), 32'h1);
        p0 = phase_out;
        step(1, 0, 32'h0, 0, 20'h0);
        chk("defer_old_step", 32'(20'(phase_out - p0)), 32'h01000);
        step(1, 0, 32'h0, 1, 20'h0);
        chk("defer_applied", 32'(ftw_pending), 32'h0);
        p0 = phase_out;
        step(1, 0, 32'h0, 0, 20'h0);
        chk("defer_new_step", 32'(20'(phase_out - p0)), 32'h02000);

        // Simultaneous load and line_sync with nothing pending.
        step(1, 1, 32'h0400_0000, 1, 20'h12345);
        chk("simul_pend", 32'(ftw_pending), 32'h1);
        p0 = phase_out;
        step(1, 0, 32'h0, 0, 20'h0);
        chk("simul_step_kept", 32'(20'(phase_out - p0)), 32'h02000);
        step(1, 0, 32'h0, 1, 20'h0);
        p0 = phase_out;
        step(1, 0, 32'h0, 0, 20'h0);
        chk("simul_step_new", 32'(20'(phase_out - p0)), 32'h04000);
        chk("simul_pend_clr", 32'(ftw_pending), 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 15) != 0, $urandom_range(0, 9) == 0, $urandom(),
                 $urandom_range(0, 19) == 0, 20'($urandom()));

        // Enable drop mid-run: delay line drains.
        for (int i = 0; i < 12; i++) step(1, 0, 32'h0, 0, 20'h0);
        step(0, 0, 32'h0, 0, 20'h0);
        chk("drop_valid", 32'(phase_valid), 32'h0);
        chk("drop_acc", 32'(phase_out), 32'h0);
        for (int i = 0; i < 9; i++) step(0, 0, 32'h0, 0, 20'h0);
        chk("drain_cv_hi", 32'(cordic_valid), 32'h1);
        step(0, 0, 32'h0, 0, 20'h0);
        chk("drain_cv_lo", 32'(cordic_valid), 32'h0);

        // Asynchronous reset mid-run, away from any clock edge.
        step(0, 1, 32'h0300_0000, 0, 20'h0);
        for (int i = 0; i < 14; i++) step(1, 0, 32'h0, 0, 20'h55555);
        step(1, 1, 32'h0700_0000, 0, 20'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 20'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_phase_gen.md
Name: nco_phase_gen

Overview:
- Numerically controlled oscillator that generates the 20-bit signed phase word driving the CORDIC sin/cos rotator for the colour-subcarrier path of the video encoder.
- Holds a 32-bit phase accumulator and realigns it to a programmable start phase at each line sync.
- Double-buffers frequency tuning word (FTW) updates so the frequency only changes on line boundaries.
- Delays valid and line-start sideband flags by the rotator latency so downstream logic stays aligned with sin/cos.

Parameters:
- ACC_WIDTH, 32: accumulator width in bits; phase_out = acc[ACC_WIDTH-1 -: 20].
- CORDIC_LATENCY, 10: sideband delay in cycles; equals the rotator STAGES.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request; low forces IDLE
- ftw_in  in  ACC_WIDTH  frequency tuning word (unsigned, fraction of a turn per cycle)
- ftw_load  in  1  single-cycle strobe; captures ftw_in into the shadow register
- line_sync  in  1  single-cycle strobe at line start
- start_phase  in  20  phase loaded at line start; 2^20 = 360 deg
- phase_out  out  20  signed phase to the rotator target_angle
- phase_valid  out  1  phase_out is meaningful
- ftw_pending  out  1  shadow FTW not yet applied
- cordic_valid  out  1  phase_valid delayed CORDIC_LATENCY cycles
- cordic_line_start  out  1  line-start marker delayed CORDIC_LATENCY cycles
- line_parity  out  1  toggles per line (only meaningful with PAL_ALT_EN)

Behaviour:
- Reset (rst_n low, async):
  - acc, ftw_active, ftw_shadow = 0; ftw_pending = 0; state = IDLE.
  - All outputs 0, including both delay lines.
- States:
  - IDLE → RUN: on enable = 1.
  - RUN → IDLE: on enable = 0.
- IDLE:
  - acc held at 0, phase_valid = 0.
  - The shadow FTW and pending flag are retained.
- IDLE→RUN edge, treated as an implicit line start:
  - acc <= start_phase << (ACC_WIDTH-20).
  - If pending, ftw_active <= ftw_shadow and pending clears.
  - phase_valid = 1 from the next cycle.
  - The line-start marker is raised for that first valid phase.
- RUN, no line_sync: acc <= acc + ftw_active every cycle.
  - Modulo 2^ACC_WIDTH, natural wrap; no saturation.
- RUN with line_sync:
  - acc <= start_phase << (ACC_WIDTH-20), discarding the accumulation for that cycle.
  - If pending, ftw_active <= ftw_shadow and pending clears.
  - Line-start marker = 1 for exactly the first cycle phase_out equals the new start phase.
- ftw_load: ftw_shadow <= ftw_in; ftw_pending <= 1.
  - A later load overwrites an earlier unapplied one.
- ftw_load and line_sync in the same cycle:
  - line_sync applies the previously pending shadow (if any).
  - The new word is captured and stays pending until the next line_sync.
- line_sync in IDLE: ignored.
- enable drop while RUN: acc cleared next cycle, phase_valid = 0 next cycle.
  - In-flight delay-line entries drain normally and are not flushed.
- phase_out:
  - Registered, equal to the acc top bits.
  - Two's complement; bits [19:18] give the rotator quadrant.
- Delay lines:
  - CORDIC_LATENCY-deep shift registers of {phase_valid, line_start}.
  - A cordic_valid high on cycle t+CORDIC_LATENCY corresponds to phase_out presented on cycle t.

Optional Feature:
- Macro: NCO_PAL_ALT_EN.
- Defined:
  - line_parity toggles on every line start; reset value 0.
  - On lines where the post-toggle parity is 1, the loaded phase is start_phase + 0x80000 (180 deg, mod 2^20).
  - Implements PAL-style alternate-line subcarrier inversion.
- Undefined:
  - line_parity tied to 0; no offset applied.

Test Plan:
- Basic accumulation:
  - Stimulus: reset, ftw_load 0x01000000, enable = 1, start_phase 0.
  - Response: phase_out = 0x00000, 0x01000, 0x02000, …; after 256 cycles it wraps to 0x00000; phase_valid = 1 from the cycle after enable.
- Line realignment:
  - Stimulus: mid-line, start_phase 0x40000, pulse line_sync.
  - Response: next phase_out = 0x40000, then 0x41000; cordic_line_start high exactly 10 cycles after phase_out = 0x40000.
- Deferred FTW:
  - Stimulus: in RUN with ftw 0x01000000, ftw_load 0x02000000 mid-line.
  - Response: step stays 0x01000 and ftw_pending = 1 until line_sync; after line_sync step = 0x02000 and ftw_pending = 0.
- Simultaneous events:
  - Stimulus: ftw_load 0x04000000 in the same cycle as line_sync, with nothing previously pending.
  - Response: step unchanged that line; ftw_pending stays 1; applied at the following line_sync.
- Reset and enable mid-run:
  - Stimulus 1: deassert enable.
  - Response 1: phase_valid = 0 next cycle; cordic_valid falls 10 cycles later.
  - Stimulus 2: assert rst_n = 0 asynchronously.
  - Response 2: all outputs 0 immediately, without waiting for a clock edge.
- NCO_PAL_ALT_EN:
  - Stimulus: start_phase 0x20000, three consecutive line_syncs.
  - Response: loaded phases 0xA0000, 0x20000, 0xA0000; line_parity 1, 0, 1.
